// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, default geometry and helpers for the sprite motion unit
//
// Contents:
//   x_t, y_t   default-width screen coordinates
//   dxy_t      default-width signed velocity component
//   rgb_t      3-bit pixel colour
//   *_DEF      default widths and visible screen size
//   div_cnt_width()  width of the frame divider counter for a given divide ratio
package sprite_pkg;

    localparam int X_WIDTH_DEF   = 10;
    localparam int Y_WIDTH_DEF   = 10;
    localparam int DXY_WIDTH_DEF = 4;
    localparam int SCREEN_W_DEF  = 640;
    localparam int SCREEN_H_DEF  = 480;

    typedef logic [X_WIDTH_DEF-1:0]          x_t;
    typedef logic [Y_WIDTH_DEF-1:0]          y_t;
    typedef logic signed [DXY_WIDTH_DEF-1:0] dxy_t;
    typedef logic [2:0]                      rgb_t;

    // A divide ratio of 1 still needs a one-bit counter that never leaves 0.
    function automatic int div_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/sprite_pixel_match.sv
// rtl/sprite_pixel_match.sv - two-stage raster-to-sprite bitmap lookup
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pixel_x, pixel_y    raster position being drawn
//   sprite_x, sprite_y  current sprite top-left corner
//   rgb_en              sprite pixel opaque, two cycles after pixel_x/y
//   rgb                 SPRITE_RGB when rgb_en, else 0
module sprite_pixel_match
    import sprite_pkg::*;
#(
    parameter int                           X_WIDTH     = X_WIDTH_DEF,
    parameter int                           Y_WIDTH     = Y_WIDTH_DEF,
    parameter int                           SPRITE_W    = 8,
    parameter int                           SPRITE_H    = 8,
    parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = '1,
    parameter rgb_t                         SPRITE_RGB  = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_WIDTH-1:0] pixel_x,
    input  logic [Y_WIDTH-1:0] pixel_y,
    input  logic [X_WIDTH-1:0] sprite_x,
    input  logic [Y_WIDTH-1:0] sprite_y,
    output logic               rgb_en,
    output rgb_t               rgb
);

    localparam int IDX_W = (SPRITE_W * SPRITE_H > 1) ? $clog2(SPRITE_W * SPRITE_H) : 1;

    // Offsets wrap modulo the coordinate width, so pixels left of or above
    // the sprite become large values and fall outside the hit window.
    logic [X_WIDTH-1:0] rx;
    logic [Y_WIDTH-1:0] ry;
    logic               hit;
    logic [IDX_W-1:0]   idx;

    assign rx  = pixel_x - sprite_x;
    assign ry  = pixel_y - sprite_y;
    assign hit = (int'(rx) < SPRITE_W) && (int'(ry) < SPRITE_H);
    // Only form a mask index on a hit so it always stays inside the mask.
    assign idx = hit ? IDX_W'(int'(ry) * SPRITE_W + int'(rx)) : '0;

    logic             s1_valid;
    logic             s1_hit;
    logic [IDX_W-1:0] s1_idx;
    logic             s2_opaque;

    assign s2_opaque = s1_valid & s1_hit & SPRITE_MASK[s1_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            rgb_en   <= 1'b0;
            rgb      <= '0;
        end else begin
            s1_valid <= 1'b1;
            s1_hit   <= hit;
            s1_idx   <= idx;
            rgb_en   <= s2_opaque;
            rgb      <= s2_opaque ? SPRITE_RGB : rgb_t'(0);
        end
    end

endmodule

// File: rtl/sprite_motion_unit.sv
// rtl/sprite_motion_unit.sv - per-sprite position/velocity state, frame-divided stepping and rendering
//
// Ports:
//   clk, rst                                  clock, asynchronous active-low reset
//   sprite_write_xy, sprite_write_x/y         load position
//   sprite_write_dxy, sprite_write_dx/dy      load signed velocity
//   sprite_enable_update                      movement enabled while high
//   frame_tick                                one pulse per frame (start of vblank)
//   pixel_x, pixel_y                          raster position being drawn
//   sprite_x, sprite_y                        current position
//   sprite_within_screen                      whole sprite visible (registered)
//   rgb_en, rgb                               sprite pixel at raster position, latency 2
module sprite_motion_unit
    import sprite_pkg::*;
#(
    parameter int                           X_WIDTH     = X_WIDTH_DEF,
    parameter int                           Y_WIDTH     = Y_WIDTH_DEF,
    parameter int                           DXY_WIDTH   = DXY_WIDTH_DEF,
    parameter int                           SCREEN_W    = SCREEN_W_DEF,
    parameter int                           SCREEN_H    = SCREEN_H_DEF,
    parameter int                           SPRITE_W    = 8,
    parameter int                           SPRITE_H    = 8,
    parameter int                           UPDATE_DIV  = 2,
    parameter logic [SPRITE_W*SPRITE_H-1:0] SPRITE_MASK = '1,
    parameter rgb_t                         SPRITE_RGB  = 3'b111
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sprite_write_xy,
    input  logic [X_WIDTH-1:0]   sprite_write_x,
    input  logic [Y_WIDTH-1:0]   sprite_write_y,
    input  logic                 sprite_write_dxy,
    input  logic [DXY_WIDTH-1:0] sprite_write_dx,
    input  logic [DXY_WIDTH-1:0] sprite_write_dy,
    input  logic                 sprite_enable_update,
    input  logic                 frame_tick,
    input  logic [X_WIDTH-1:0]   pixel_x,
    input  logic [Y_WIDTH-1:0]   pixel_y,
    output logic [X_WIDTH-1:0]   sprite_x,
    output logic [Y_WIDTH-1:0]   sprite_y,
    output logic                 sprite_within_screen,
    output logic                 rgb_en,
    output rgb_t                 rgb
);

    localparam int DIV_W = div_cnt_width(UPDATE_DIV);

    logic [X_WIDTH-1:0]          pos_x;
    logic [Y_WIDTH-1:0]          pos_y;
    logic signed [DXY_WIDTH-1:0] vel_dx;
    logic signed [DXY_WIDTH-1:0] vel_dy;
    logic [DIV_W-1:0]            div_cnt;
    logic                        within_q;

    logic step_req;
    logic div_wrap;

    assign step_req = frame_tick & sprite_enable_update;
    assign div_wrap = (div_cnt == DIV_W'(UPDATE_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_x    <= '0;
            pos_y    <= '0;
            vel_dx   <= '0;
            vel_dy   <= '0;
            div_cnt  <= '0;
            within_q <= 1'b1;
        end else begin
            // The step below reads the velocity registers before this load
            // lands, so a same-cycle velocity write only affects later steps.
            if (sprite_write_dxy) begin
                vel_dx <= sprite_write_dx;
                vel_dy <= sprite_write_dy;
            end

            // An explicit position write overrides any step due this cycle
            // and restarts the frame divider.
            if (sprite_write_xy) begin
                pos_x   <= sprite_write_x;
                pos_y   <= sprite_write_y;
                div_cnt <= '0;
            end else if (step_req) begin
                if (div_wrap) begin
                    div_cnt <= '0;
                    // Signed width cast sign-extends; the sum wraps at the coordinate width.
                    pos_x   <= pos_x + X_WIDTH'(vel_dx);
                    pos_y   <= pos_y + Y_WIDTH'(vel_dy);
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end

            // Unsigned compare: a coordinate that wrapped below zero reads as
            // a huge value and is therefore reported off screen.
            within_q <= (int'(pos_x) <= SCREEN_W - SPRITE_W) &&
                        (int'(pos_y) <= SCREEN_H - SPRITE_H);
        end
    end

    assign sprite_x             = pos_x;
    assign sprite_y             = pos_y;
    assign sprite_within_screen = within_q;

    sprite_pixel_match #(
        .X_WIDTH     (X_WIDTH),
        .Y_WIDTH     (Y_WIDTH),
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H),
        .SPRITE_MASK (SPRITE_MASK),
        .SPRITE_RGB  (SPRITE_RGB)
    ) u_pixel_match (
        .clk      (clk),
        .rst      (rst),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .sprite_x (pos_x),
        .sprite_y (pos_y),
        .rgb_en   (rgb_en),
        .rgb      (rgb)
    );

endmodule

// File: tb/tb_sprite_motion_unit.sv
// tb/tb_sprite_motion_unit.sv - scoreboard bench for sprite_motion_unit
module tb_sprite_motion_unit;

    localparam int SIG_X      = 0;
    localparam int SIG_Y      = 1;
    localparam int SIG_WITHIN = 2;
    localparam int SIG_RGB_EN = 3;
    localparam int SIG_RGB    = 4;

    typedef struct {
        int    at_cyc;
        int    sig;
        int    val;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sprite_write_xy = 1'b0;
    logic [9:0] sprite_write_x = '0;
    logic [9:0] sprite_write_y = '0;
    logic       sprite_write_dxy = 1'b0;
    logic [3:0] sprite_write_dx = '0;
    logic [3:0] sprite_write_dy = '0;
    logic       sprite_enable_update = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic       sprite_within_screen;
    logic       rgb_en;
    logic [2:0] rgb;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    sprite_motion_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .frame_tick           (frame_tick),
        .pixel_x              (pixel_x),
        .pixel_y              (pixel_y),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .rgb_en               (rgb_en),
        .rgb                  (rgb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at_cyc <= cyc) begin
                    int act;
                    case (sb[i].sig)
                        SIG_X:      act = int'(sprite_x);
                        SIG_Y:      act = int'(sprite_y);
                        SIG_WITHIN: act = int'(sprite_within_screen);
                        SIG_RGB_EN: act = int'(rgb_en);
                        default:    act = int'(rgb);
                    endcase
                    n_cmp++;
                    if (sb[i].at_cyc < cyc || act != sb[i].val) begin
                        n_fail++;
                        $display("FAIL %s @cyc %0d: got %0d expected %0d", sb[i].name, cyc, act, sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic expect_in(input int delay, input int sig, input int val, input string name);
        exp_t e;
        e.at_cyc = cyc + delay;
        e.sig    = sig;
        e.val    = val;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic expect_pos(input int delay, input int x, input int y, input string name);
        expect_in(delay, SIG_X, x, {name, ".x"});
        expect_in(delay, SIG_Y, y, {name, ".y"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_xy(input int x, input int y);
        sprite_write_xy = 1'b1;
        sprite_write_x  = 10'(x);
        sprite_write_y  = 10'(y);
    endtask

    task automatic write_dxy(input int dx, input int dy);
        sprite_write_dxy = 1'b1;
        sprite_write_dx  = 4'(dx);
        sprite_write_dy  = 4'(dy);
    endtask

    task automatic release_strobes();
        sprite_write_xy  = 1'b0;
        sprite_write_dxy = 1'b0;
        frame_tick       = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1;
        tick();
        release_strobes();
        tick();
    endtask

    task automatic pixel_probe(input int px, input int py, input int en, input string name);
        pixel_x = 10'(px);
        pixel_y = 10'(py);
        expect_in(2, SIG_RGB_EN, en, {name, ".rgb_en"});
        expect_in(2, SIG_RGB, en ? 7 : 0, {name, ".rgb"});
        tick();
        release_strobes();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        expect_pos(0, 0, 0, "reset");
        expect_in(0, SIG_WITHIN, 1, "reset.within");
        expect_in(0, SIG_RGB_EN, 0, "reset.rgb_en");
        expect_in(0, SIG_RGB, 0, "reset.rgb");
        tick();
        tick();
        n_cmp++;
        if (sprite_x !== 10'd0 || sprite_y !== 10'd0) begin
            n_fail++;
            $display("FAIL reset.direct.pos: got (%0d,%0d) expected (0,0)", sprite_x, sprite_y);
        end
        n_cmp++;
        if (sprite_within_screen !== 1'b1) begin
            n_fail++;
            $display("FAIL reset.direct.within: got %0d expected 1", sprite_within_screen);
        end
        n_cmp++;
        if (rgb_en !== 1'b0 || rgb !== 3'd0) begin
            n_fail++;
            $display("FAIL reset.direct.rgb: got en=%0d rgb=%0d expected en=0 rgb=0", rgb_en, rgb);
        end
        rst = 1'b1;
        tick();

        write_xy(100, 50);
        write_dxy(2, -1);
        sprite_enable_update = 1'b1;
        expect_pos(1, 100, 50, "load100");
        tick();
        release_strobes();
        pulse_frame();
        expect_pos(1, 102, 49, "step1");
        pulse_frame();
        pulse_frame();
        expect_pos(1, 104, 48, "step2");
        expect_in(2, SIG_WITHIN, 1, "step2.within");
        pulse_frame();

        write_xy(630, 100);
        write_dxy(1, 0);
        expect_pos(1, 630, 100, "load630");
        expect_in(2, SIG_WITHIN, 1, "load630.within");
        tick();
        release_strobes();
        pulse_frame();
        expect_in(1, SIG_X, 631, "edge631.x");
        expect_in(2, SIG_WITHIN, 1, "edge631.within");
        pulse_frame();
        pulse_frame();
        expect_in(1, SIG_X, 632, "edge632.x");
        expect_in(2, SIG_WITHIN, 1, "edge632.within");
        pulse_frame();
        pulse_frame();
        expect_in(1, SIG_X, 633, "edge633.x");
        expect_in(1, SIG_WITHIN, 1, "edge633.within_lag");
        expect_in(2, SIG_WITHIN, 0, "edge633.within");
        pulse_frame();

        write_xy(0, 0);
        write_dxy(-1, 0);
        expect_in(2, SIG_WITHIN, 1, "origin.within");
        tick();
        release_strobes();
        pulse_frame();
        expect_pos(1, 1023, 0, "wrap");
        expect_in(2, SIG_WITHIN, 0, "wrap.within");
        pulse_frame();

        sprite_enable_update = 1'b0;
        write_xy(10, 20);
        write_dxy(1, 1);
        tick();
        release_strobes();
        pulse_frame();
        pulse_frame();
        expect_pos(0, 10, 20, "hold");
        n_cmp++;
        if (sprite_x !== 10'd10 || sprite_y !== 10'd20) begin
            n_fail++;
            $display("FAIL hold.direct: got (%0d,%0d) expected (10,20)", sprite_x, sprite_y);
        end

        pixel_probe(17, 27, 1, "px17_27");
        pixel_probe(18, 27, 0, "px18_27");
        pixel_probe(10, 20, 1, "px10_20");
        pixel_probe(9, 20, 0, "px9_20");
        pixel_probe(10, 28, 0, "px10_28");
        write_xy(11, 20);
        pixel_probe(10, 20, 1, "pxmove_old");
        pixel_probe(10, 20, 0, "pxmove_new");
        tick();
        tick();

        sprite_enable_update = 1'b1;
        write_xy(100, 100);
        tick();
        release_strobes();
        pulse_frame();
        write_xy(5, 5);
        expect_pos(1, 5, 5, "xywins");
        pulse_frame();
        expect_pos(1, 5, 5, "xywins_div1");
        pulse_frame();
        expect_pos(1, 6, 6, "xywins_step");
        pulse_frame();
        pulse_frame();
        write_dxy(3, 0);
        expect_pos(1, 7, 7, "dxy_old");
        pulse_frame();
        pulse_frame();
        expect_pos(1, 10, 7, "dxy_new");
        pulse_frame();

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            n_fail++;
            $display("FAIL %s: got never-checked expected check by cyc %0d", sb[0].name, sb[0].at_cyc);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
